// File: rtl/sing_io_tristate_sched.sv
// Two-requester scheduler for one shared OBUFT-style tristate pad.
// Grants fixed-length drive windows, round-robin, separated by high-Z turnaround.
module sing_io_tristate_sched #(
    parameter int HOLD_CYCLES = 4,
    parameter int TURN_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       din0,
    input  logic       din1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       io_i,
    output logic       io_t
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_TURN
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic       r_last;
    logic       w_win;
    logic       w_owner;
    logic       w_din;
    logic [1:0] r_gnt;
    logic       r_busy;
    logic       r_done;
    logic       r_io_i;
    logic       r_io_t;

    // Tie goes to whoever was not granted last; r_last resets to 1 so 0 wins.
    always_comb begin
        w_win = 1'b0;
        case (req)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_next     = S_DRIVE;
                    w_cnt_next = CNT_W'(HOLD_CYCLES);
                end
            end
            S_DRIVE: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next     = S_TURN;
                    w_cnt_next = CNT_W'(TURN_CYCLES);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_TURN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    assign w_owner = (r_state == S_IDLE) ? w_win : r_last;
    assign w_din   = w_owner ? din1 : din0;

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_io_i  <= 1'b0;
            r_io_t  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && w_next == S_DRIVE) begin
                r_last <= w_win;
            end
            if (w_next == S_DRIVE) begin
                r_gnt <= w_owner ? 2'b10 : 2'b01;
            end else begin
                r_gnt <= 2'b00;
            end
            r_busy <= (w_next != S_IDLE);
            r_done <= (r_state == S_DRIVE) && (w_next == S_TURN);
            r_io_i <= (w_next == S_DRIVE) & w_din;
            r_io_t <= (w_next != S_DRIVE);
        end
    end

    assign gnt  = r_gnt;
    assign busy = r_busy;
    assign done = r_done;
    assign io_i = r_io_i;
    assign io_t = r_io_t;

endmodule

// File: tb/tb_sing_io_tristate_sched.sv
// Directed bench for sing_io_tristate_sched (HOLD=4, TURN=2).
// Inputs change #1 after each rising edge; outputs are sampled there too.
module tb_sing_io_tristate_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic       din0;
    logic       din1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       io_i;
    logic       io_t;

    int errors = 0;
    int checks = 0;

    sing_io_tristate_sched #(
        .HOLD_CYCLES(4),
        .TURN_CYCLES(2),
        .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .din0(din0),
        .din1(din1),
        .gnt (gnt),
        .busy(busy),
        .done(done),
        .io_i(io_i),
        .io_t(io_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 2'b00;
        din0 = 1'b0;
        din1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt got=%b exp=00", gnt);
        end
        checks++;
        if (io_t !== 1'b1 || io_i !== 1'b0) begin
            errors++;
            $display("FAIL reset_pad got t=%b i=%b exp t=1 i=0", io_t, io_i);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_single();
        logic       drv;
        logic [1:0] eg;
        do_reset();
        req  = 2'b01;
        din0 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            drv = (c <= 4) || (c == 8);
            eg  = drv ? 2'b01 : 2'b00;
            checks++;
            if (gnt !== eg || io_t !== !drv || io_i !== drv) begin
                errors++;
                $display("FAIL single_c%0d got gnt=%b t=%b i=%b exp gnt=%b t=%b i=%b",
                         c, gnt, io_t, io_i, eg, !drv, drv);
            end
            checks++;
            if (done !== (c == 5) || busy !== (c != 7)) begin
                errors++;
                $display("FAIL single_flags_c%0d got done=%b busy=%b exp done=%b busy=%b",
                         c, done, busy, (c == 5), (c != 7));
            end
        end
    endtask

    task automatic test_both();
        int         ph;
        int         win;
        logic       drv;
        logic [1:0] eg;
        do_reset();
        req  = 2'b11;
        din0 = 1'b0;
        din1 = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            ph  = (c - 1) % 7;
            win = (c - 1) / 7;
            drv = (ph < 4);
            eg  = drv ? ((win % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if (gnt !== eg || io_t !== !drv || done !== (ph == 4)) begin
                errors++;
                $display("FAIL both_c%0d got gnt=%b t=%b done=%b exp gnt=%b t=%b done=%b",
                         c, gnt, io_t, done, eg, !drv, (ph == 4));
            end
            checks++;
            if (io_i !== (drv && (win % 2 == 1))) begin
                errors++;
                $display("FAIL both_data_c%0d got i=%b exp i=%b",
                         c, io_i, (drv && (win % 2 == 1)));
            end
        end
    endtask

    task automatic test_data();
        logic pat [0:4];
        logic ei;
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b1;
        pat[3] = 1'b0;
        pat[4] = 1'b1;
        do_reset();
        req  = 2'b01;
        din0 = pat[0];
        for (int c = 1; c <= 5; c++) begin
            tick();
            din0 = pat[c % 5];
            if (c == 4) din0 = 1'b1;
            ei = (c <= 4) ? pat[c-1] : 1'b0;
            checks++;
            if (io_i !== ei || io_t !== (c == 5)) begin
                errors++;
                $display("FAIL data_c%0d got i=%b t=%b exp i=%b t=%b",
                         c, io_i, io_t, ei, (c == 5));
            end
        end
        req = 2'b00;
    endtask

    task automatic test_drop();
        logic       drv;
        logic [1:0] eg;
        do_reset();
        req  = 2'b01;
        din0 = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 2) req = 2'b00;
            drv = (c <= 4);
            eg  = drv ? 2'b01 : 2'b00;
            checks++;
            if (gnt !== eg || io_t !== !drv || busy !== (c <= 6)) begin
                errors++;
                $display("FAIL drop_c%0d got gnt=%b t=%b busy=%b exp gnt=%b t=%b busy=%b",
                         c, gnt, io_t, busy, eg, !drv, (c <= 6));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req  = 2'b01;
        din0 = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 2'b01 || io_t !== 1'b0) begin
            errors++;
            $display("FAIL rmid_pre got gnt=%b t=%b exp gnt=01 t=0", gnt, io_t);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (io_t !== 1'b1 || gnt !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_post got t=%b gnt=%b busy=%b done=%b exp 1 00 0 0",
                     io_t, gnt, busy, done);
        end
        rst = 1'b0;
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01 || io_i !== 1'b1) begin
            errors++;
            $display("FAIL rmid_first got gnt=%b i=%b exp gnt=01 i=1", gnt, io_i);
        end
    endtask

    task automatic test_idle();
        do_reset();
        din0 = 1'b1;
        din1 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (io_t !== 1'b1 || io_i !== 1'b0 || busy !== 1'b0 || done !== 1'b0
                || gnt !== 2'b00) begin
                errors++;
                $display("FAIL idle_c%0d got t=%b i=%b busy=%b done=%b gnt=%b",
                         c, io_t, io_i, busy, done, gnt);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 2'b00;
        din0 = 1'b0;
        din1 = 1'b0;
        test_reset();
        test_single();
        test_both();
        test_data();
        test_drop();
        test_reset_mid();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
